addr_sync_buffer: RTL and testbench
===================================

// Module: addr_sync_buffer
// PURPOSE
//   Single-clock, addressed storage buffer with FIFO-style occupancy flags.
//   One block serves two roles: the instruction memory (32-bit words, filled by the bus host, read by the PC)
//   and the input-feature buffer (16-bit words, filled by the bus host, read during MAC sequencing).
//   Writes and reads use explicit addresses; the full/empty flags track a count of stored words.
// PARAMETERS
//   DATA_WIDTH  32  word width (set to 16 for the input-buffer role)
//   ADDR_WIDTH  6   address width; DEPTH = 2**ADDR_WIDTH words (derived localparam, 64 by default)
// PORTS
//   clk               in   1           single clock; all state updates on rising edge
//   rst               in   1           reset, synchronous, active-low
//   wr_cs             in   1           write chip-select
//   wr_en             in   1           write enable; write requested when wr_cs & wr_en
//   address_to_write  in   ADDR_WIDTH  write address
//   data_in           in   DATA_WIDTH  write data
//   rd_cs             in   1           read chip-select
//   rd_en             in   1           read enable; read requested when rd_cs & rd_en
//   address_to_read   in   ADDR_WIDTH  read address
//   data_out          out  DATA_WIDTH  registered read data
//   empty             out  1           count == 0
//   full              out  1           count == DEPTH
// BEHAVIOUR
//   - Reset (rst==0 at a rising edge): data_out=0, count=0, so empty=1 and full=0. Memory contents are not cleared.
//     Reset has priority over any request in the same cycle. A mid-operation reset aborts pending writes/reads.
//   - count: ADDR_WIDTH+1 bits, range 0..DEPTH. empty and full are decoded combinationally from the count register,
//     so they change one cycle after the accepted access.
//   - Write accept = wr_cs & wr_en & ~full.
//     Accepted write: mem[address_to_write] <= data_in.
//     A write while full is dropped: memory and count are unchanged, and no error flag is raised.
//   - Read = rd_cs & rd_en. A read is always performed regardless of empty (random access).
//     data_out <= mem[address_to_read]; latency is 1 cycle.
//     data_out holds its last value when no read is requested.
//   - Read counts as consumption only when ~empty: count decrements only if count>0.
//     Reading while empty leaves count at 0 (no underflow).
//   - Count update rules:
//       accepted write only -> +1
//       consuming read only -> -1
//       both in the same cycle -> unchanged
//       neither -> unchanged
//   - Addresses wrap naturally within ADDR_WIDTH bits; there are no internal pointers and no address checks.
//   - Same-cycle read and write to the same address: read-before-write, so data_out gets the OLD word
//     (unless the BYPASS option below is compiled in).
//   - Count never exceeds DEPTH and never goes below 0.
// CONFIGURATION
//   ADDR_SYNC_BUFFER_BYPASS_EN
//     defined: when an accepted write and a read hit the same address in one cycle, data_out <= data_in
//              (write-through forwarding).
//     undefined: data_out <= previous mem contents (read-before-write). Default build leaves it undefined.
// TESTING
//   1. Reset: hold rst=0 for 2 clks with wr/rd active -> data_out=0, empty=1, full=0; no count change after release.
//   2. Write 0xDEADBEEF @5, then read @5 -> data_out=0xDEADBEEF exactly 1 cycle after the read edge;
//      empty goes 1->0 after the write, back to 1 after the read.
//   3. Fill: 64 accepted writes to addrs 0..63 -> full=1 after the 64th.
//      65th write (addr 0, data 0x1234) is dropped; read @0 returns the original word.
//   4. Simultaneous write+read with count=3 -> count stays 3.
//      Read on empty buffer -> empty stays 1 and data_out = stored mem word.
//   5. Same-address collision: mem[7]=0xA, write 0xB @7 while reading @7 -> data_out=0xA
//      (0xB with ADDR_SYNC_BUFFER_BYPASS_EN); the next read @7 gives 0xB.
//   6. DATA_WIDTH=16 instance: write 0xFFFF @63, read @63 -> 0xFFFF; rd_cs=1, rd_en=0 -> data_out holds.

Source files
------------

// File: rtl/addr_sync_buffer.sv
// rtl/addr_sync_buffer.sv - addressed storage buffer with count-based full/empty flags
// Optional macro ADDR_SYNC_BUFFER_BYPASS_EN forwards write data to a same-address read.
module addr_sync_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_cs,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] address_to_write,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_cs,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] address_to_read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   count;

  logic wr_accept;
  logic rd_req;
  logic rd_consume;

  assign empty      = (count == '0);
  assign full       = (count == DEPTH_CNT);
  assign wr_accept  = wr_cs & wr_en & ~full;
  assign rd_req     = rd_cs & rd_en;
  assign rd_consume = rd_req & ~empty;

  // Contents survive reset; only the write itself is suppressed while rst is low.
  always_ff @(posedge clk) begin
    if (rst && wr_accept) begin
      mem[address_to_write] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out <= '0;
    end else if (rd_req) begin
`ifdef ADDR_SYNC_BUFFER_BYPASS_EN
      if (wr_accept && (address_to_write == address_to_read)) begin
        data_out <= data_in;
      end else begin
        data_out <= mem[address_to_read];
      end
`else
      data_out <= mem[address_to_read];
`endif
    end
  end

  // A write blocked by full and a read on empty both leave count alone, so it stays in 0..DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({wr_accept, rd_consume})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_sync_buffer.sv
// tb/tb_addr_sync_buffer.sv - directed self-checking bench for addr_sync_buffer
module tb_addr_sync_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_wr_cs, a_wr_en, a_rd_cs, a_rd_en;
  logic [5:0]  a_waddr, a_raddr;
  logic [31:0] a_din, a_dout;
  logic        a_empty, a_full;

  logic        b_wr_cs, b_wr_en, b_rd_cs, b_rd_en;
  logic [5:0]  b_waddr, b_raddr;
  logic [15:0] b_din, b_dout;
  logic        b_empty, b_full;

  int tests = 0;
  int failed = 0;

  addr_sync_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut_a (
    .clk(clk), .rst(rst),
    .wr_cs(a_wr_cs), .wr_en(a_wr_en), .address_to_write(a_waddr), .data_in(a_din),
    .rd_cs(a_rd_cs), .rd_en(a_rd_en), .address_to_read(a_raddr),
    .data_out(a_dout), .empty(a_empty), .full(a_full)
  );

  addr_sync_buffer #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut_b (
    .clk(clk), .rst(rst),
    .wr_cs(b_wr_cs), .wr_en(b_wr_en), .address_to_write(b_waddr), .data_in(b_din),
    .rd_cs(b_rd_cs), .rd_en(b_rd_en), .address_to_read(b_raddr),
    .data_out(b_dout), .empty(b_empty), .full(b_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_wr_cs = 0; a_wr_en = 0; a_rd_cs = 0; a_rd_en = 0;
  endtask

  task automatic a_write(input logic [5:0] addr, input logic [31:0] d);
    a_wr_cs = 1; a_wr_en = 1; a_waddr = addr; a_din = d;
  endtask

  task automatic a_read(input logic [5:0] addr);
    a_rd_cs = 1; a_rd_en = 1; a_raddr = addr;
  endtask

  logic [31:0] exp_coll;

  initial begin
    a_idle();
    a_waddr = 0; a_raddr = 0; a_din = 0;
    b_wr_cs = 0; b_wr_en = 0; b_rd_cs = 0; b_rd_en = 0;
    b_waddr = 0; b_raddr = 0; b_din = 0;

    // 1. reset with requests active
    rst = 0;
    a_write(6'd3, 32'h5555_5555);
    a_read(6'd3);
    tick(); tick();
    check("rst_dout", a_dout, 32'h0);
    check("rst_empty", {31'b0, a_empty}, 32'd1);
    check("rst_full", {31'b0, a_full}, 32'd0);
    check("rst_b_dout", {16'b0, b_dout}, 32'h0);
    check("rst_b_empty", {31'b0, b_empty}, 32'd1);
    rst = 1;
    a_idle();
    tick();
    check("post_rst_empty", {31'b0, a_empty}, 32'd1);

    // 2. single write then read
    a_write(6'd5, 32'hDEAD_BEEF);
    tick();
    check("wr5_empty", {31'b0, a_empty}, 32'd0);
    a_idle();
    a_read(6'd5);
    tick();
    check("rd5_data", a_dout, 32'hDEAD_BEEF);
    check("rd5_empty", {31'b0, a_empty}, 32'd1);
    a_idle();
    tick();
    check("hold_data", a_dout, 32'hDEAD_BEEF);

    // 3. fill to full, dropped write, drain
    for (int i = 0; i < 64; i++) begin
      a_write(6'(i), 32'h1000_0000 + 32'(i));
      tick();
      if (i == 62) check("fill63_full", {31'b0, a_full}, 32'd0);
    end
    check("fill64_full", {31'b0, a_full}, 32'd1);
    a_write(6'd0, 32'h0000_1234);
    tick();
    check("drop_full", {31'b0, a_full}, 32'd1);
    a_idle();
    a_read(6'd0);
    tick();
    check("drop_rd0", a_dout, 32'h1000_0000);
    check("drop_rd_full", {31'b0, a_full}, 32'd0);
    a_read(6'd63);
    for (int i = 0; i < 63; i++) tick();
    check("drain_rd63", a_dout, 32'h1000_003F);
    check("drain_empty", {31'b0, a_empty}, 32'd1);

    // 4. simultaneous write+read at count 3, then read on empty
    a_idle();
    a_write(6'd10, 32'hAAAA_0010); tick();
    a_write(6'd11, 32'hAAAA_0011); tick();
    a_write(6'd12, 32'hAAAA_0012); tick();
    a_write(6'd13, 32'hAAAA_0013);
    a_read(6'd10);
    tick();
    check("sim_rd10", a_dout, 32'hAAAA_0010);
    a_idle();
    a_read(6'd13);
    tick(); tick();
    check("cnt3_after2", {31'b0, a_empty}, 32'd0);
    tick();
    check("cnt3_after3", {31'b0, a_empty}, 32'd1);
    check("rd13_data", a_dout, 32'hAAAA_0013);
    a_read(6'd11);
    tick();
    check("rd_empty_data", a_dout, 32'hAAAA_0011);
    check("rd_empty_flag", {31'b0, a_empty}, 32'd1);

    // 5. same-address collision
    a_idle();
    a_write(6'd7, 32'h0000_000A);
    tick();
    a_read(6'd7);
    a_write(6'd7, 32'h0000_000B);
    tick();
`ifdef ADDR_SYNC_BUFFER_BYPASS_EN
    exp_coll = 32'h0000_000B;
`else
    exp_coll = 32'h0000_000A;
`endif
    check("coll_data", a_dout, exp_coll);
    check("coll_cnt1", {31'b0, a_empty}, 32'd0);
    a_idle();
    a_read(6'd7);
    tick();
    check("coll_next", a_dout, 32'h0000_000B);
    check("coll_empty", {31'b0, a_empty}, 32'd1);
    a_idle();

    // 6. 16-bit instance at the top address
    b_wr_cs = 1; b_wr_en = 1; b_waddr = 6'd63; b_din = 16'hFFFF;
    tick();
    b_wr_cs = 0; b_wr_en = 0;
    check("b_wr_empty", {31'b0, b_empty}, 32'd0);
    b_rd_cs = 1; b_rd_en = 1; b_raddr = 6'd63;
    tick();
    check("b_rd63", {16'b0, b_dout}, 32'h0000_FFFF);
    b_rd_en = 0; b_raddr = 6'd0;
    tick(); tick();
    check("b_hold", {16'b0, b_dout}, 32'h0000_FFFF);
    check("b_empty", {31'b0, b_empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
